// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch sequencer: owns the fetch PC, keeps one imem read in flight and buffers words for decode.
// Optional fetch-bubble counter is built when IFETCH_BUBBLE_CNT_EN is defined; otherwise bubble_cnt_out is 0.
module instr_fetch_ctrl #(
  parameter int unsigned     PC_W       = 12,
  parameter logic [PC_W-1:0] RESET_PC   = '0,
  parameter int unsigned     FIFO_DEPTH = 2
) (
  input  logic            clk_in,
  input  logic            rst_low_in,
  output logic            imem_req_out,
  output logic [PC_W-1:0] imem_addr_out,
  input  logic            imem_gnt_in,
  input  logic            imem_rvalid_in,
  input  logic [31:0]     imem_rdata_in,
  input  logic            redirect_in,
  input  logic [PC_W-1:0] redirect_pc_in,
  input  logic            stall_in,
  output logic            instr_valid_out,
  output logic [31:0]     raw_instr_out,
  output logic [PC_W-1:0] instr_pc_out,
  output logic [31:0]     bubble_cnt_out
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  state_e            state_q;
  state_e            state_d;
  logic [PC_W-1:0]   pc_q;
  logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];
  logic [PC_W-1:0]   fifo_pc_q   [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [CNT_W-1:0]  count_q;

  logic fifo_empty;
  logic fifo_full;
  logic push;
  logic pop;
  logic pc_adv;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    logic [PTR_W-1:0] r;
    if (p == PTR_W'(FIFO_DEPTH - 1)) r = '0;
    else                             r = p + PTR_W'(1);
    return r;
  endfunction

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));

  // State register
  always_ff @(posedge clk_in or negedge rst_low_in) begin
    if (!rst_low_in) state_q <= ST_FETCH;
    else             state_q <= state_d;
  end

  // Next state, request/valid handshakes and FIFO push/pop strobes; redirect wins over everything
  always_comb begin
    state_d         = state_q;
    imem_req_out    = 1'b0;
    instr_valid_out = 1'b0;
    push            = 1'b0;
    pop             = 1'b0;
    pc_adv          = 1'b0;

    imem_req_out    = (state_q == ST_FETCH) && !fifo_full && !redirect_in && rst_low_in;
    instr_valid_out = !fifo_empty && !redirect_in;
    pop             = instr_valid_out && !stall_in;

    case (state_q)
      ST_FETCH: begin
        if (!redirect_in && imem_req_out && imem_gnt_in) begin
          state_d = ST_WAIT;
          pc_adv  = 1'b1;
        end
      end
      ST_WAIT: begin
        if (imem_rvalid_in) begin
          state_d = ST_FETCH;
          push    = !redirect_in;
        end else if (redirect_in) begin
          state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (imem_rvalid_in) state_d = ST_FETCH;
      end
      default: state_d = ST_FETCH;
    endcase
  end

  // Fetch PC; a redirect target is word-aligned by dropping its low two bits
  always_ff @(posedge clk_in or negedge rst_low_in) begin
    if (!rst_low_in) begin
      pc_q <= RESET_PC;
    end else if (redirect_in) begin
      pc_q <= {redirect_pc_in[PC_W-1:2], 2'b00};
    end else if (pc_adv) begin
      pc_q <= pc_q + PC_W'(4);
    end
  end

  assign imem_addr_out = pc_q;

  // Instruction buffer pointers and occupancy
  always_ff @(posedge clk_in or negedge rst_low_in) begin
    if (!rst_low_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (redirect_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Buffer storage; the PC has already advanced past the word being returned
  always_ff @(posedge clk_in or negedge rst_low_in) begin
    if (!rst_low_in) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        fifo_data_q[i] <= '0;
        fifo_pc_q[i]   <= '0;
      end
    end else if (push) begin
      fifo_data_q[wr_ptr_q] <= imem_rdata_in;
      fifo_pc_q[wr_ptr_q]   <= pc_q - PC_W'(4);
    end
  end

  assign raw_instr_out = fifo_data_q[rd_ptr_q];
  assign instr_pc_out  = fifo_pc_q[rd_ptr_q];

`ifdef IFETCH_BUBBLE_CNT_EN
  logic [31:0] bubble_cnt_q;

  // Counts cycles where decode is starved, saturating
  always_ff @(posedge clk_in or negedge rst_low_in) begin
    if (!rst_low_in) begin
      bubble_cnt_q <= '0;
    end else if (fifo_empty && !redirect_in && (bubble_cnt_q != '1)) begin
      bubble_cnt_q <= bubble_cnt_q + 32'd1;
    end
  end

  assign bubble_cnt_out = bubble_cnt_q;
`else
  assign bubble_cnt_out = '0;
`endif

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed table-driven bench for instr_fetch_ctrl: streaming, stall fill, redirects, PC wrap, reset, bubble counter.
module tb_instr_fetch_ctrl;

  localparam bit H = 1'b1;
  localparam bit L = 1'b0;
`ifdef IFETCH_BUBBLE_CNT_EN
  localparam bit BUB_EN = 1'b1;
`else
  localparam bit BUB_EN = 1'b0;
`endif

  logic        clk_in;
  logic        rst_low_in;
  logic        imem_req_out;
  logic [11:0] imem_addr_out;
  logic        imem_gnt_in;
  logic        imem_rvalid_in;
  logic [31:0] imem_rdata_in;
  logic        redirect_in;
  logic [11:0] redirect_pc_in;
  logic        stall_in;
  logic        instr_valid_out;
  logic [31:0] raw_instr_out;
  logic [11:0] instr_pc_out;
  logic [31:0] bubble_cnt_out;

  instr_fetch_ctrl dut (
    .clk_in          (clk_in),
    .rst_low_in      (rst_low_in),
    .imem_req_out    (imem_req_out),
    .imem_addr_out   (imem_addr_out),
    .imem_gnt_in     (imem_gnt_in),
    .imem_rvalid_in  (imem_rvalid_in),
    .imem_rdata_in   (imem_rdata_in),
    .redirect_in     (redirect_in),
    .redirect_pc_in  (redirect_pc_in),
    .stall_in        (stall_in),
    .instr_valid_out (instr_valid_out),
    .raw_instr_out   (raw_instr_out),
    .instr_pc_out    (instr_pc_out),
    .bubble_cnt_out  (bubble_cnt_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  typedef struct {
    logic        rst_n;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        redir;
    logic [11:0] rpc;
    logic        stall;
    logic        e_req;
    logic [11:0] e_addr;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [11:0] e_pc;
  } vec_t;

  vec_t vecs[$];
  int   n_pass  = 0;
  int   n_total = 0;

  function automatic vec_t v(logic r, logic g, logic rv, logic [31:0] rd, logic rdr,
                             logic [11:0] rp, logic st, logic er, logic [11:0] ea,
                             logic ev, logic [31:0] ei, logic [11:0] ep);
    vec_t t;
    t.rst_n = r;  t.gnt = g;    t.rvalid = rv;  t.rdata = rd; t.redir = rdr;
    t.rpc   = rp; t.stall = st; t.e_req = er;   t.e_addr = ea;
    t.e_valid = ev; t.e_instr = ei; t.e_pc = ep;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    else             n_pass++;
  endtask

  // Drive one cycle's inputs at the falling edge and check outputs 1ns later
  task automatic step(input vec_t r, input int idx);
    @(negedge clk_in);
    rst_low_in     = r.rst_n;
    imem_gnt_in    = r.gnt;
    imem_rvalid_in = r.rvalid;
    imem_rdata_in  = r.rdata;
    redirect_in    = r.redir;
    redirect_pc_in = r.rpc;
    stall_in       = r.stall;
    #1;
    chk($sformatf("req[%0d]", idx),   32'(imem_req_out),    32'(r.e_req));
    chk($sformatf("addr[%0d]", idx),  32'(imem_addr_out),   32'(r.e_addr));
    chk($sformatf("valid[%0d]", idx), 32'(instr_valid_out), 32'(r.e_valid));
    if (r.e_valid || !r.rst_n) begin
      chk($sformatf("instr[%0d]", idx), raw_instr_out,      r.e_instr);
      chk($sformatf("ipc[%0d]", idx),   32'(instr_pc_out),  32'(r.e_pc));
    end
  endtask

  vec_t rst_row;
  vec_t frows[6];
  int   bub_exp[6];

  initial begin
    rst_low_in     = 1'b0;
    imem_gnt_in    = 1'b0;
    imem_rvalid_in = 1'b0;
    imem_rdata_in  = '0;
    redirect_in    = 1'b0;
    redirect_pc_in = '0;
    stall_in       = 1'b0;

    rst_row = v(L,L,L,32'h0,L,12'h0,L, L,12'h000,L,32'h0,12'h000);

    // Streaming: immediate grant, rvalid one cycle later, no stall
    vecs.push_back(rst_row);
    vecs.push_back(v(H,H,L,32'h0,L,12'h0,L,        H,12'h000,L,32'h0,12'h000));
    vecs.push_back(v(H,L,H,32'hA000_0000,L,12'h0,L, L,12'h004,L,32'h0,12'h000));
    vecs.push_back(v(H,H,L,32'h0,L,12'h0,L,        H,12'h004,H,32'hA000_0000,12'h000));
    vecs.push_back(v(H,L,H,32'hA000_0004,L,12'h0,L, L,12'h008,L,32'h0,12'h000));
    vecs.push_back(v(H,H,L,32'h0,L,12'h0,L,        H,12'h008,H,32'hA000_0004,12'h004));
    vecs.push_back(v(H,L,H,32'hA000_0008,L,12'h0,L, L,12'h00C,L,32'h0,12'h000));
    vecs.push_back(v(H,L,L,32'h0,L,12'h0,L,        H,12'h00C,H,32'hA000_0008,12'h008));
    // Stall while buffer fills; grant with no request is ignored
    vecs.push_back(rst_row);
    vecs.push_back(v(H,H,L,32'h0,L,12'h0,H,        H,12'h000,L,32'h0,12'h000));
    vecs.push_back(v(H,L,H,32'hB000_0000,L,12'h0,H, L,12'h004,L,32'h0,12'h000));
    vecs.push_back(v(H,H,L,32'h0,L,12'h0,H,        H,12'h004,H,32'hB000_0000,12'h000));
    vecs.push_back(v(H,L,H,32'hB000_0004,L,12'h0,H, L,12'h008,H,32'hB000_0000,12'h000));
    vecs.push_back(v(H,L,L,32'h0,L,12'h0,H,        L,12'h008,H,32'hB000_0000,12'h000));
    vecs.push_back(v(H,H,L,32'h0,L,12'h0,H,        L,12'h008,H,32'hB000_0000,12'h000));
    vecs.push_back(v(H,L,L,32'h0,L,12'h0,L,        L,12'h008,H,32'hB000_0000,12'h000));
    vecs.push_back(v(H,H,L,32'h0,L,12'h0,L,        H,12'h008,H,32'hB000_0004,12'h004));
    vecs.push_back(v(H,L,H,32'hB000_0008,L,12'h0,L, L,12'h00C,L,32'h0,12'h000));
    vecs.push_back(v(H,L,L,32'h0,L,12'h0,L,        H,12'h00C,H,32'hB000_0008,12'h008));
    // Redirect to 0x103 while waiting: in-flight word discarded
    vecs.push_back(rst_row);
    vecs.push_back(v(H,H,L,32'h0,L,12'h0,L,        H,12'h000,L,32'h0,12'h000));
    vecs.push_back(v(H,L,L,32'h0,H,12'h103,L,      L,12'h004,L,32'h0,12'h000));
    vecs.push_back(v(H,L,L,32'h0,L,12'h0,L,        L,12'h100,L,32'h0,12'h000));
    vecs.push_back(v(H,L,H,32'hDEAD_BEEF,L,12'h0,L, L,12'h100,L,32'h0,12'h000));
    vecs.push_back(v(H,H,L,32'h0,L,12'h0,L,        H,12'h100,L,32'h0,12'h000));
    vecs.push_back(v(H,L,H,32'hC000_0100,L,12'h0,L, L,12'h104,L,32'h0,12'h000));
    vecs.push_back(v(H,L,L,32'h0,L,12'h0,L,        H,12'h104,H,32'hC000_0100,12'h100));
    vecs.push_back(v(H,L,L,32'h0,L,12'h0,L,        H,12'h104,L,32'h0,12'h000));
    // Redirect coincident with rvalid and a would-be pop
    vecs.push_back(rst_row);
    vecs.push_back(v(H,H,L,32'h0,L,12'h0,L,        H,12'h000,L,32'h0,12'h000));
    vecs.push_back(v(H,L,H,32'hE000_0000,L,12'h0,L, L,12'h004,L,32'h0,12'h000));
    vecs.push_back(v(H,H,L,32'h0,L,12'h0,H,        H,12'h004,H,32'hE000_0000,12'h000));
    vecs.push_back(v(H,L,H,32'hE000_0004,H,12'h200,L, L,12'h008,L,32'h0,12'h000));
    vecs.push_back(v(H,H,L,32'h0,L,12'h0,L,        H,12'h200,L,32'h0,12'h000));
    vecs.push_back(v(H,L,H,32'hE000_0200,L,12'h0,L, L,12'h204,L,32'h0,12'h000));
    vecs.push_back(v(H,L,L,32'h0,L,12'h0,L,        H,12'h204,H,32'hE000_0200,12'h200));
    // Redirect from FETCH to 0xFFE, then PC wrap; stray rvalid in FETCH ignored
    vecs.push_back(rst_row);
    vecs.push_back(v(H,L,L,32'h0,H,12'hFFE,L,      L,12'h000,L,32'h0,12'h000));
    vecs.push_back(v(H,H,L,32'h0,L,12'h0,L,        H,12'hFFC,L,32'h0,12'h000));
    vecs.push_back(v(H,L,H,32'hF000_0FFC,L,12'h0,L, L,12'h000,L,32'h0,12'h000));
    vecs.push_back(v(H,L,L,32'h0,L,12'h0,L,        H,12'h000,H,32'hF000_0FFC,12'hFFC));
    vecs.push_back(v(H,L,H,32'h1234_0000,L,12'h0,L, H,12'h000,L,32'h0,12'h000));
    vecs.push_back(v(H,L,L,32'h0,L,12'h0,L,        H,12'h000,L,32'h0,12'h000));
    // Reset while waiting; the late response then lands in FETCH and is ignored
    vecs.push_back(v(H,H,L,32'h0,L,12'h0,L,        H,12'h000,L,32'h0,12'h000));
    vecs.push_back(rst_row);
    vecs.push_back(v(H,L,H,32'h9999_9999,L,12'h0,L, H,12'h000,L,32'h0,12'h000));
    vecs.push_back(v(H,L,L,32'h0,L,12'h0,L,        H,12'h000,L,32'h0,12'h000));

    foreach (vecs[i]) step(vecs[i], i);

    // Bubble counter with a 3-cycle response delay, stall held once data arrives
    frows[0] = v(H,H,L,32'h0,L,12'h0,H,         H,12'h000,L,32'h0,12'h000);
    frows[1] = v(H,L,L,32'h0,L,12'h0,H,         L,12'h004,L,32'h0,12'h000);
    frows[2] = v(H,L,L,32'h0,L,12'h0,H,         L,12'h004,L,32'h0,12'h000);
    frows[3] = v(H,L,H,32'h1234_5678,L,12'h0,H, L,12'h004,L,32'h0,12'h000);
    frows[4] = v(H,L,L,32'h0,L,12'h0,H,         H,12'h004,H,32'h1234_5678,12'h000);
    frows[5] = v(H,L,L,32'h0,L,12'h0,H,         H,12'h004,H,32'h1234_5678,12'h000);
    bub_exp  = '{0, 1, 2, 3, 4, 4};

    step(rst_row, 1000);
    chk("bubble_rst", bubble_cnt_out, 32'd0);
    for (int i = 0; i < 6; i++) begin
      step(frows[i], 1001 + i);
      chk($sformatf("bubble[%0d]", i), bubble_cnt_out, BUB_EN ? 32'(bub_exp[i]) : 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/instr_fetch_ctrl.md
# instr_fetch_ctrl

Instruction fetch sequencer sitting between the instruction memory port and `instr_decoder`. It owns the fetch PC, issues one-outstanding word reads to instruction memory and buffers returned words with their PCs in a small FIFO. It presents them as `instr_valid`/`raw_instr`/`instr_pc` to the decode stage, and handles stalls from downstream and PC redirects from branch/jump resolution, including discarding in-flight responses.

## Interface
- `PC_W`, 12: fetch PC width; matches decoder `instr_pc_in`.
- `RESET_PC`, `'0`: PC fetched first after reset. Bits [1:0] must be 0.
- `FIFO_DEPTH`, 2: instruction buffer entries, ≥1, power of 2.

Ports:
- `clk_in`  in  1  clock; all logic on posedge.
- `rst_low_in`  in  1  reset, asynchronous, active-low.
- `imem_req_out`  out  1  read request.
- `imem_addr_out`  out  PC_W  byte address of request, equals fetch PC.
- `imem_gnt_in`  in  1  request accepted this cycle.
- `imem_rvalid_in`  in  1  read data valid; exactly one per granted request, ≥1 cycle after grant.
- `imem_rdata_in`  in  32  instruction word.
- `redirect_in`  in  1  PC redirect (taken branch/jump).
- `redirect_pc_in`  in  PC_W  redirect target; bits [1:0] forced to 0.
- `stall_in`  in  1  downstream cannot accept this cycle.
- `instr_valid_out`  out  1  FIFO head valid.
- `raw_instr_out`  out  32  FIFO head word.
- `instr_pc_out`  out  PC_W  FIFO head PC.
- `bubble_cnt_out`  out  32  fetch-bubble counter (see Configuration).

## Operation
- FSM states: FETCH (no request outstanding), WAIT (one granted, awaiting rvalid), FLUSH (one granted, response to be discarded).
- `imem_req_out` = state==FETCH && fifo_count < FIFO_DEPTH && !redirect_in; forced 0 while reset asserted.
- FETCH: on `imem_gnt_in` with request high → WAIT, pc <= pc+4 (modulo 2^PC_W, wraps to 0).
- WAIT: on `imem_rvalid_in` push {rdata, request PC} → FETCH.
- FLUSH: on `imem_rvalid_in` drop data → FETCH.
- `imem_rvalid_in` in FETCH is ignored.
- Pop: `instr_valid_out && !stall_in`. Push+pop same cycle: count unchanged.
- `instr_valid_out` = fifo non-empty && !redirect_in.
- Redirect (priority over everything): FIFO cleared, pc <= redirect_pc_in & ~3. Next state: WAIT or FLUSH with no rvalid this cycle → FLUSH; WAIT with rvalid this cycle → FETCH (data dropped); FETCH → FETCH (no request is issued in the redirect cycle); FLUSH with rvalid → FETCH, otherwise stays FLUSH.
- FIFO overflow is impossible: a request is issued only with a free entry, and only one request is outstanding.

## Timing
- Reset values: state FETCH, pc RESET_PC, FIFO empty, `imem_req_out` 0, `imem_addr_out` RESET_PC, `instr_valid_out` 0, `raw_instr_out` 0, `instr_pc_out` 0, `bubble_cnt_out` 0.
- First request is asserted in the first cycle after reset deassertion.
- Latency: grant in cycle N, rvalid in N+1, then `instr_valid_out` in N+2. The next request is issued in N+2. Peak throughput is 1 instruction per 2 cycles.
- Outputs are stable while `instr_valid_out && stall_in`.
- If reset is asserted mid-operation, all state clears immediately and any pending response is ignored.

## Configuration
- `IFETCH_BUBBLE_CNT_EN` defined: `bubble_cnt_out` increments (saturating at 2^32-1) each cycle out of reset with FIFO empty and no redirect. It clears on reset only.
- Not defined: no counter logic; `bubble_cnt_out` is tied to 0.

## Test plan
- Reset release, memory grants immediately, rvalid +1 cycle with no stall: PCs 0x000, 0x004, 0x008 appear on `instr_pc_out` in cycles 3, 5, 7 with matching rdata.
- Hold `stall_in`=1 while FIFO_DEPTH=2 fills: `imem_req_out` goes 0 after 2 entries, head stays PC 0x000. Release stall: entries pop in order and requests resume.
- Redirect to 0x103 while in WAIT: next rvalid data is discarded and the next request address is 0x100. `instr_valid_out` stays 0 until the 0x100 word returns.
- Redirect in the same cycle as rvalid and a head pop: the FIFO empties, the word is dropped, no instruction is accepted, and FETCH resumes at the target next cycle.
- PC at 0xFFC: the next request address wraps to 0x000.
- With `IFETCH_BUBBLE_CNT_EN`, 3-cycle rvalid delay from reset: `bubble_cnt_out` counts every empty cycle and stops when the first instruction becomes valid. Without the macro it stays 0.
